// File: rtl/div4_vector.sv
// div4_vector: sixteen-lane bit-sliced restoring divider.
// Each lane divides a 4-bit dividend by a 2-bit divisor, one quotient bit per
// iteration, MSB first. Operands and results travel as bit-planes (bit k of
// every lane packed into one LANES-wide word), matching the mul4 datapath.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE and out_valid only in DONE, so the two
// handshakes can never coincide. The producer holds operands stable while
// in_valid is high. The consumer may stall DONE indefinitely by holding
// out_ready low, and the result stays constant while it does.
module div4_vector #(
  parameter int LANES = 16,
  parameter int ITER  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] q3,
  output logic [LANES-1:0] q2,
  output logic [LANES-1:0] q1,
  output logic [LANES-1:0] q0,
  output logic [LANES-1:0] r1,
  output logic [LANES-1:0] r0,
  output logic [LANES-1:0] dbz,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The first iteration works on the dividend MSB.
  localparam logic [1:0] CNT_INIT = 2'(ITER - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       accept;

  // Per-lane working registers, captured at accept.
  logic [3:0] dvd  [LANES];
  logic [1:0] dvs  [LANES];
  logic [1:0] prem [LANES];
  logic [3:0] quo  [LANES];

  // Per-lane combinational iteration step.
  logic [2:0]       p_try [LANES];
  logic [1:0]       p_nxt [LANES];
  logic [3:0]       q_nxt [LANES];
  logic [LANES-1:0] q_bit;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_DIV;
      end
      S_DIV: begin
        if (cnt == 2'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step per lane: shift in the next dividend bit, subtract the
  // divisor when it fits. The shifted partial remainder needs 3 bits, but the
  // stored remainder always ends below the divisor, so 2 bits are kept.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      p_try[i] = {prem[i], dvd[i][cnt]};
      q_bit[i] = (p_try[i] >= {1'b0, dvs[i]});
      p_nxt[i] = q_bit[i] ? 2'(p_try[i] - {1'b0, dvs[i]}) : p_try[i][1:0];
      q_nxt[i] = quo[i] | (4'(q_bit[i]) << cnt);
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      q3  <= '0;
      q2  <= '0;
      q1  <= '0;
      q0  <= '0;
      r1  <= '0;
      r0  <= '0;
      dbz <= '0;
      for (int i = 0; i < LANES; i++) begin
        dvd[i]  <= 4'd0;
        dvs[i]  <= 2'd0;
        prem[i] <= 2'd0;
        quo[i]  <= 4'd0;
      end
    end else if (accept) begin
      cnt <= CNT_INIT;
      for (int i = 0; i < LANES; i++) begin
        dvd[i]  <= {y3[i], y2[i], y1[i], y0[i]};
        dvs[i]  <= {b1[i], b0[i]};
        prem[i] <= 2'd0;
        quo[i]  <= 4'd0;
      end
    end else if (state == S_DIV) begin
      cnt <= cnt - 2'd1;
      for (int i = 0; i < LANES; i++) begin
        prem[i] <= p_nxt[i];
        quo[i]  <= q_nxt[i];
      end
      // Last iteration publishes the result; zero divisors are overridden.
      if (cnt == 2'd0) begin
        for (int i = 0; i < LANES; i++) begin
          if (dvs[i] == 2'd0) begin
            dbz[i] <= 1'b1;
            q3[i]  <= 1'b1;
            q2[i]  <= 1'b1;
            q1[i]  <= 1'b1;
            q0[i]  <= 1'b1;
            r1[i]  <= 1'b0;
            r0[i]  <= 1'b0;
          end else begin
            dbz[i] <= 1'b0;
            q3[i]  <= q_nxt[i][3];
            q2[i]  <= q_nxt[i][2];
            q1[i]  <= q_nxt[i][1];
            q0[i]  <= q_nxt[i][0];
            r1[i]  <= p_nxt[i][1];
            r0[i]  <= p_nxt[i][0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_div4_vector.sv
// Self-checking bench for div4_vector: directed operations, backpressure,
// mid-operation reset, a shuffled exhaustive sweep and a mul4 round trip.
module tb_div4_vector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y3, y2, y1, y0, b1, b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q3, q2, q1, q0, r1, r0, dbz;
  logic [1:0]  dbg_state;
  logic [111:0] res;

  int checks   = 0;
  int failures = 0;
  logic [111:0] exp_q[$];

  div4_vector #(.LANES(16), .ITER(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0), .b1(b1), .b0(b0),
    .out_valid(out_valid), .out_ready(out_ready),
    .q3(q3), .q2(q2), .q1(q1), .q0(q0), .r1(r1), .r0(r0), .dbz(dbz),
    .dbg_state(dbg_state)
  );

  assign res = {q3, q2, q1, q0, r1, r0, dbz};

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Comparison point
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer divide per lane.
  function automatic logic [111:0] model(input logic [15:0] a3, a2, a1, a0, c1, c0);
    logic [15:0] e3, e2, e1, e0, f1, f0, z;
    int d, b, q, r;
    e3 = '0; e2 = '0; e1 = '0; e0 = '0; f1 = '0; f0 = '0; z = '0;
    for (int i = 0; i < 16; i++) begin
      d = {a3[i], a2[i], a1[i], a0[i]};
      b = {c1[i], c0[i]};
      if (b == 0) begin
        q = 15; r = 0; z[i] = 1'b1;
      end else begin
        q = d / b; r = d % b;
      end
      e3[i] = q[3]; e2[i] = q[2]; e1[i] = q[1]; e0[i] = q[0];
      f1[i] = r[1]; f0[i] = r[0];
    end
    return {e3, e2, e1, e0, f1, f0, z};
  endfunction

  // Driver: wait for in_ready (bounded), present operands for one edge.
  task automatic accept_op(input logic [15:0] a3, a2, a1, a0, c1, c0);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_ready", in_ready, 1);
    y3 = a3; y2 = a2; y1 = a1; y0 = a0; b1 = c1; b0 = c0;
    in_valid = 1'b1;
    exp_q.push_back(model(a3, a2, a1, a0, c1, c0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_taken", in_ready, 0);
  endtask

  // Latency check plus scoreboard compare; leaves the bench in DONE.
  task automatic expect_result(input string tag);
    logic [111:0] e;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard observed=empty required=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, res, e);
    end
  endtask

  // Result handshake with out_ready already high.
  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] l3, l2, l1, l0, lb1, lb0;
    logic [111:0] snap;
    logic [3:0] dd;
    logic [1:0] bb;
    int perm[64];
    int k, j, tmp;

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    y3 = '0; y2 = '0; y1 = '0; y0 = '0; b1 = '0; b0 = '0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // D=15 B=3
    accept_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    expect_result("d15_b3");
    check("d15_b3_q", {q3, q2, q1, q0}, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF});
    check("d15_b3_r", {r1, r0, dbz}, 48'h0);
    release_op("d15_b3");

    // D=14 B=3
    accept_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);
    expect_result("d14_b3");
    check("d14_b3_r1", r1, 16'hFFFF);
    release_op("d14_b3");

    // D=7 B=2
    accept_op(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    expect_result("d7_b2");
    check("d7_b2_r0", r0, 16'hFFFF);
    release_op("d7_b2");

    // Mixed lanes
    for (int i = 0; i < 16; i++) begin
      dd = 4'd15; bb = 2'd1;
      if (i == 0)  begin dd = 4'd9;  bb = 2'd2; end
      if (i == 1)  begin dd = 4'd0;  bb = 2'd1; end
      if (i == 15) begin dd = 4'd11; bb = 2'd0; end
      l3[i] = dd[3]; l2[i] = dd[2]; l1[i] = dd[1]; l0[i] = dd[0];
      lb1[i] = bb[1]; lb0[i] = bb[0];
    end
    accept_op(l3, l2, l1, l0, lb1, lb0);
    expect_result("mixed");
    check("mixed_dbz", dbz, 16'h8000);
    check("mixed_lane0_q", {q3[0], q2[0], q1[0], q0[0]}, 4'd4);
    release_op("mixed");

    // Backpressure: DONE held for 10 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    accept_op(16'hA5A5, 16'h3C3C, 16'h0FF0, 16'h9669, 16'hF0F0, 16'hCCCC);
    expect_result("bp");
    snap = res;
    for (int c = 0; c < 10; c++) begin
      y3 = 16'($urandom_range(65535, 0)); y2 = 16'($urandom_range(65535, 0));
      y1 = 16'($urandom_range(65535, 0)); y0 = 16'($urandom_range(65535, 0));
      b1 = 16'($urandom_range(65535, 0)); b0 = 16'($urandom_range(65535, 0));
      in_valid = c[0];
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_outputs", res, snap);
    end
    in_valid = 1'b0;
    release_op("bp");
    check("bp_outputs_kept", res, snap);
    accept_op(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);
    expect_result("bp_next");
    release_op("bp_next");

    // Reset two cycles after accept
    accept_op(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_outputs", res, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out_valid", out_valid, 0);
    rst_n = 1'b1;
    accept_op(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
    expect_result("after_rst");
    check("after_rst_q", {q3, q2, q1, q0, r1, r0}, {16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0});
    release_op("after_rst");

    // Shuffled exhaustive sweep of all 64 (D,B) pairs over 4 operations
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 16; i++) begin
        k = perm[op * 16 + i];
        dd = 4'(k >> 2);
        bb = 2'(k & 3);
        l3[i] = dd[3]; l2[i] = dd[2]; l1[i] = dd[1]; l0[i] = dd[0];
        lb1[i] = bb[1]; lb0[i] = bb[0];
      end
      accept_op(l3, l2, l1, l0, lb1, lb0);
      expect_result("sweep");
      release_op("sweep");
    end

    // mul4 round trip: D = A*B, recovered Q must equal A with R = 0
    for (int i = 0; i < 16; i++) begin
      dd = 4'((i >> 2) * (i & 3));
      bb = 2'(i & 3);
      l3[i] = dd[3]; l2[i] = dd[2]; l1[i] = dd[1]; l0[i] = dd[0];
      lb1[i] = bb[1]; lb0[i] = bb[0];
    end
    accept_op(l3, l2, l1, l0, lb1, lb0);
    expect_result("roundtrip");
    for (int i = 0; i < 16; i++) begin
      if ((i & 3) != 0) begin
        check("roundtrip_q", {q3[i], q2[i], q1[i], q0[i]}, 4'(i >> 2));
        check("roundtrip_r", {r1[i], r0[i]}, 2'd0);
      end
    end
    release_op("roundtrip");

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
